// File: rtl/melody_sequencer_if.sv
// ROM address/data bus between the melody sequencer and the combinational note ROM.
interface melody_sequencer_if #(
    parameter int BW    = 16,
    parameter int IDX_W = 6
);
    logic [IDX_W-1:0] note_index_o;
    logic [BW-1:0]    divider_value_i;

    modport master (output note_index_o, input divider_value_i);
    modport slave  (input note_index_o, output divider_value_i);
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a note index through the ROM at a fixed slot rate and
// turns each returned divider value into a square-wave tone.
module melody_sequencer #(
    parameter int BW        = 16,
    parameter int IDX_W     = 6,
    parameter int NUM_NOTES = 64,
    parameter int TICK_DIV  = 1500000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                enable_i,
    input  logic                loop_i,
    melody_sequencer_if.master  rom,
    output logic                tone_o,
    output logic                playing_o,
    output logic                done_o
);

    localparam int SW = $clog2(TICK_DIV);
    localparam logic [SW-1:0]    SLOT_LAST = SW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NOTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [BW-1:0]    tone_cnt_q, tone_cnt_d;
    logic             tone_q, tone_d;
    logic             playing_q, playing_d;
    logic             done_q, done_d;

    assign rom.note_index_o = idx_q;
    assign tone_o           = tone_q;
    assign playing_o        = playing_q;
    assign done_o           = done_q;

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            slot_q     <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_q     <= slot_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
        end
    end

    // Next-state, slot stepping and tone generation.
    always_comb begin
        state_d    = state_q;
        idx_d      = '0;
        slot_d     = '0;
        tone_cnt_d = '0;
        tone_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PLAY: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (rom.divider_value_i == {BW{1'b0}}) begin
                        tone_cnt_d = '0;
                        tone_d     = 1'b0;
                    end else if (tone_cnt_q == rom.divider_value_i - BW'(1)) begin
                        tone_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + BW'(1);
                        tone_d     = tone_q;
                    end

                    // Slot end restarts the next note low with a full half-period.
                    if (slot_q == SLOT_LAST) begin
                        slot_d     = '0;
                        tone_cnt_d = '0;
                        tone_d     = 1'b0;
                        if (idx_q < IDX_LAST) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else if (loop_i) begin
                            idx_d = '0;
                        end else begin
                            idx_d   = '0;
                            state_d = ST_DONE;
                        end
                    end else begin
                        slot_d = slot_q + SW'(1);
                        idx_d  = idx_q;
                    end
                end
            end

            ST_DONE: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        playing_d = (state_d == ST_PLAY);
        done_d    = (state_d == ST_DONE);
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with a 4-entry stub ROM and 16-cycle slots.
module tb_melody_sequencer;

    localparam int BW = 16;
    localparam int IDX_W = 6;
    localparam int NUM_NOTES = 4;
    localparam int TICK_DIV = 16;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic loop_en = 1'b0;
    logic tone, playing, done;
    logic [BW-1:0] rom_tbl [4];

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q [$];

    melody_sequencer_if #(.BW(BW), .IDX_W(IDX_W)) rom_if ();

    assign rom_if.divider_value_i = rom_tbl[rom_if.note_index_o[1:0]];

    melody_sequencer #(
        .BW(BW), .IDX_W(IDX_W), .NUM_NOTES(NUM_NOTES), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enable_i  (enable),
        .loop_i    (loop_en),
        .rom       (rom_if.master),
        .tone_o    (tone),
        .playing_o (playing),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    // Expected {index, tone, playing, done} k edges after entering PLAY.
    function automatic logic [8:0] exp_vec(int k, int done_at);
        int idx, p, d;
        logic t;
        if (k >= done_at) return {6'd0, 1'b0, 1'b0, 1'b1};
        idx = (k / TICK_DIV) % NUM_NOTES;
        p   = k % TICK_DIV;
        d   = int'(rom_tbl[idx]);
        t   = (d == 0) ? 1'b0 : 1'(((p / d) % 2));
        return {6'(idx), t, 1'b1, 1'b0};
    endfunction

    function automatic logic [8:0] observed();
        return {rom_if.note_index_o, tone, playing, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        #3 rst_n = 1'b0;
        #1;
        exp_q.push_back(9'd0);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", observed(), e);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(9'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL reset_idle i=%0d got=%h exp=%h", i, observed(), e);
            end
        end
    endtask

    // Enable and check k = 0..last; optionally drop loop_i after loop_off_k.
    task automatic play_run(string name, int last, int done_at, int loop_off_k);
        logic [8:0] e;
        enable = 1'b1;
        for (int k = 0; k <= last; k++) begin
            exp_q.push_back(exp_vec(k, done_at));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL %s k=%0d got=%h exp=%h", name, k, observed(), e);
            end
            if (k == loop_off_k) loop_en = 1'b0;
        end
    endtask

    task automatic abort_to_idle(string name);
        logic [8:0] e;
        enable = 1'b0;
        exp_q.push_back(9'd0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL %s_abort got=%h exp=%h", name, observed(), e);
        end
    endtask

    task automatic test_play_basic();
        for (int i = 0; i < 4; i++) rom_tbl[i] = 16'd3;
        play_run("basic", 70, 64, -1);
        abort_to_idle("basic");
    endtask

    task automatic test_silence();
        rom_tbl[0] = 16'd3; rom_tbl[1] = 16'd0; rom_tbl[2] = 16'd3; rom_tbl[3] = 16'd2;
        play_run("silence", 66, 64, -1);
        abort_to_idle("silence");
    endtask

    task automatic test_loop();
        rom_tbl[0] = 16'd1; rom_tbl[1] = 16'd5; rom_tbl[2] = 16'd3; rom_tbl[3] = 16'd4;
        loop_en = 1'b1;
        // loop_i drops in slot 6 (index 2); the next last-slot end is at edge 128.
        play_run("loop", 135, 128, 100);
        abort_to_idle("loop");
    endtask

    task automatic test_abort_replay();
        for (int i = 0; i < 4; i++) rom_tbl[i] = 16'd3;
        play_run("abort_mid", 20, NEVER, -1);
        abort_to_idle("abort_mid");
        play_run("replay", 17, NEVER, -1);
        abort_to_idle("replay");
    endtask

    task automatic test_abort_at_last_slot_end();
        play_run("abort_last", 63, 64, -1);
        abort_to_idle("abort_last");
    endtask

    task automatic test_done_hold();
        rom_tbl[0] = 16'd2; rom_tbl[1] = 16'd3; rom_tbl[2] = 16'd1; rom_tbl[3] = 16'd7;
        play_run("done_hold", 114, 64, -1);
        abort_to_idle("done_hold");
        play_run("done_replay", 2, NEVER, -1);
        abort_to_idle("done_replay");
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        for (int i = 0; i < 4; i++) rom_tbl[i] = 16'd3;
        play_run("pre_rst", 4, NEVER, -1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.push_back(9'd0);
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL async_rst got=%h exp=%h", observed(), e);
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(9'd0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL post_rst_idle i=%0d got=%h exp=%h", i, observed(), e);
            end
        end
        play_run("post_rst_play", 18, NEVER, -1);
        abort_to_idle("post_rst");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rom_tbl[i] = 16'd3;
        test_reset();
        test_play_basic();
        test_silence();
        test_loop();
        test_abort_replay();
        test_abort_at_last_slot_end();
        test_done_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
